// File: rtl/calc_port_engine.sv
// calc_port_engine: single-stage ALU request engine feeding an in-order response FIFO.
// Results are computed at acceptance, held one edge in the stage, then pushed to the FIFO.
module calc_port_engine #(
   parameter int         DATA_W     = 32,
   parameter int         TAG_W      = 2,
   parameter logic [7:0] PORT_ID    = 8'h31,
   parameter int         FIFO_DEPTH = 4,
   parameter bit         SAT_MODE   = 1'b0
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          req_valid,
   output logic                          req_ready,
   input  logic [3:0]                    req_cmd,
   input  logic [TAG_W-1:0]              req_tag,
   input  logic [DATA_W-1:0]             req_data1,
   input  logic [DATA_W-1:0]             req_data2,
   output logic                          rsp_valid,
   input  logic                          rsp_ready,
   output logic [7:0]                    rsp_port,
   output logic [3:0]                    rsp_cmd,
   output logic [TAG_W-1:0]              rsp_tag,
   output logic [1:0]                    rsp_resp,
   output logic [DATA_W-1:0]             rsp_data,
   output logic                          rsp_flow,
   output logic [15:0]                   err_count,
   output logic [$clog2(FIFO_DEPTH):0]   occupancy
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int SW = $clog2(DATA_W);

   typedef struct packed {
      logic [3:0]        cmd;
      logic [TAG_W-1:0]  tag;
      logic [1:0]        resp;
      logic [DATA_W-1:0] data;
      logic              flow;
   } ent_t;

   ent_t              w_calc, w_head, r_stg;
   ent_t              r_mem [FIFO_DEPTH];
   logic              r_stg_v;
   logic [AW-1:0]     r_wp, r_rp;
   logic [AW:0]       r_cnt;
   logic [15:0]       r_err;
   logic [DATA_W:0]   w_sum;
   logic [SW-1:0]     w_sa;
   logic              w_acc, w_push, w_pop;

   always_comb begin
      w_sum       = {1'b0, req_data1} + {1'b0, req_data2};
      w_sa        = req_data2[SW-1:0];
      w_calc.cmd  = req_cmd;
      w_calc.tag  = req_tag;
      w_calc.resp = 2'd1;
      w_calc.flow = 1'b0;
      w_calc.data = '0;
      case (req_cmd)
         4'd1: begin
            w_calc.resp = w_sum[DATA_W] ? 2'd2 : 2'd1;
            w_calc.flow = w_sum[DATA_W];
            w_calc.data = w_sum[DATA_W] ? {DATA_W{SAT_MODE}} : w_sum[DATA_W-1:0];
         end
         4'd2: begin
            w_calc.resp = (req_data1 < req_data2) ? 2'd2 : 2'd1;
            w_calc.flow = req_data1 < req_data2;
            w_calc.data = (req_data1 < req_data2) ? '0 : req_data1 - req_data2;
         end
         4'd3:    w_calc.data = req_data1 & req_data2;
         4'd4:    w_calc.data = req_data1 | req_data2;
         4'd5:    w_calc.data = req_data1 << w_sa;
         4'd6:    w_calc.data = req_data1 >> w_sa;
         4'd7:    w_calc.data = $signed(req_data1) >>> w_sa;
         default: w_calc.resp = 2'd2;
      endcase
   end

   // Space check counts the stage entry, so the stage can always drain into the FIFO.
   assign occupancy = r_cnt + (AW+1)'(r_stg_v);
   assign req_ready = reset && (occupancy < (AW+1)'(FIFO_DEPTH));
   assign w_acc     = req_valid && req_ready;
   assign w_push    = r_stg_v;
   assign w_pop     = rsp_valid && rsp_ready;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_stg_v <= 1'b0;
         r_stg   <= '0;
         r_wp    <= '0;
         r_rp    <= '0;
         r_cnt   <= '0;
         r_err   <= '0;
      end else begin
         r_stg_v <= w_acc && (req_cmd != 4'd0);
         if (w_acc) r_stg <= w_calc;
         if (w_push) r_wp <= r_wp + AW'(1);
         if (w_pop) r_rp <= r_rp + AW'(1);
         r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
         if (w_push && r_stg.resp == 2'd2 && r_err != 16'hFFFF) r_err <= r_err + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wp] <= r_stg;
   end

   assign w_head    = r_mem[r_rp];
   assign rsp_valid = r_cnt != '0;
   assign rsp_port  = PORT_ID;
   assign rsp_cmd   = rsp_valid ? w_head.cmd  : '0;
   assign rsp_tag   = rsp_valid ? w_head.tag  : '0;
   assign rsp_resp  = rsp_valid ? w_head.resp : '0;
   assign rsp_data  = rsp_valid ? w_head.data : '0;
   assign rsp_flow  = rsp_valid ? w_head.flow : 1'b0;
   assign err_count = r_err;
endmodule

// File: tb/tb_calc_port_engine.sv
// tb_calc_port_engine: scoreboard bench; expected responses are queued at acceptance
// and compared against the FIFO head every cycle.
module tb_calc_port_engine;
   localparam int DW = 32, TW = 2, FD = 4;

   logic            clk = 1'b0, rst_n = 1'b0;
   logic            req_valid = 1'b0, rsp_ready = 1'b0;
   logic [3:0]      req_cmd = '0;
   logic [TW-1:0]   req_tag = '0;
   logic [DW-1:0]   d1 = '0, d2 = '0;
   logic            req_ready, rsp_valid, rsp_flow;
   logic [7:0]      rsp_port;
   logic [3:0]      rsp_cmd;
   logic [TW-1:0]   rsp_tag;
   logic [1:0]      rsp_resp;
   logic [DW-1:0]   rsp_data;
   logic [15:0]     err_count;
   logic [$clog2(FD):0] occupancy;

   typedef struct packed {
      logic [3:0]    cmd;
      logic [TW-1:0] tag;
      logic [1:0]    resp;
      logic [DW-1:0] data;
      logic          flow;
   } exp_t;

   exp_t sbq[$];
   int   n_cmp = 0, n_bad = 0, n_cyc = 0, n_pop = 0, exp_err = 0;

   always #5 clk = ~clk;

   calc_port_engine dut (
      .clk(clk), .reset(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd), .req_tag(req_tag),
      .req_data1(d1), .req_data2(d2),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_port(rsp_port), .rsp_cmd(rsp_cmd),
      .rsp_tag(rsp_tag), .rsp_resp(rsp_resp), .rsp_data(rsp_data), .rsp_flow(rsp_flow),
      .err_count(err_count), .occupancy(occupancy)
   );

   function automatic exp_t model(input logic [3:0] c, input logic [TW-1:0] t,
                                  input logic [DW-1:0] a, input logic [DW-1:0] b);
      exp_t          e;
      int            sa;
      logic [DW-1:0] s, ones;
      ones = '1;
      sa = int'(b[4:0]);
      e = '{cmd: c, tag: t, resp: 2'd1, data: '0, flow: 1'b0};
      case (c)
         4'd1: begin
            s = a + b;
            if (s < a) begin e.resp = 2'd2; e.flow = 1'b1; end else e.data = s;
         end
         4'd2: if (a < b) begin e.resp = 2'd2; e.flow = 1'b1; end else e.data = a - b;
         4'd3: e.data = a & b;
         4'd4: e.data = a | b;
         4'd5: e.data = a << sa;
         4'd6: e.data = a >> sa;
         4'd7: e.data = (a >> sa) | (a[DW-1] ? ~(ones >> sa) : '0);
         default: e.resp = 2'd2;
      endcase
      return e;
   endfunction

   // One clock: check head against scoreboard, log acceptance, advance to next negedge.
   task automatic sb_cycle(output bit acc);
      exp_t got, e;
      #1;
      acc = req_valid && req_ready;
      got = '{rsp_cmd, rsp_tag, rsp_resp, rsp_data, rsp_flow};
      n_cmp++;
      if (rsp_valid) begin
         if (sbq.size() == 0) begin
            n_bad++;
            $display("FAIL sb_unexpected: got %h, none expected", got);
         end else begin
            if (got !== sbq[0] || rsp_port !== 8'h31) begin
               n_bad++;
               $display("FAIL sb_rsp: got %h port %h, expected %h port 31", got, rsp_port, sbq[0]);
            end
            if (rsp_ready) begin void'(sbq.pop_front()); n_pop++; end
         end
      end else if (got !== '0) begin
         n_bad++;
         $display("FAIL idle_zero: got %h, expected 0", got);
      end
      if (acc && req_cmd != 4'd0) begin
         e = model(req_cmd, req_tag, d1, d2);
         sbq.push_back(e);
         if (e.resp == 2'd2) exp_err++;
      end
      n_cyc++;
      @(negedge clk);
   endtask

   task automatic send(input logic [3:0] c, input logic [TW-1:0] t,
                       input logic [DW-1:0] a, input logic [DW-1:0] b);
      bit acc;
      int k;
      req_valid = 1'b1; req_cmd = c; req_tag = t; d1 = a; d2 = b;
      acc = 1'b0; k = 0;
      while (!acc && k < 50) begin sb_cycle(acc); k++; end
      n_cmp++;
      if (!acc) begin n_bad++; $display("FAIL send_timeout: accepted %0d, required 1", acc); end
      req_valid = 1'b0;
   endtask

   task automatic drain(input int budget);
      bit acc;
      int k;
      rsp_ready = 1'b1;
      k = 0;
      while (sbq.size() != 0 && k < budget) begin sb_cycle(acc); k++; end
      n_cmp++;
      if (sbq.size() != 0) begin n_bad++; $display("FAIL drain_timeout: left %0d, required 0", sbq.size()); end
      #1;
      n_cmp++;
      if (err_count !== 16'(exp_err)) begin
         n_bad++; $display("FAIL err_count: got %0d, required %0d", err_count, exp_err);
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      #1;
      n_cmp++;
      if ({rsp_valid, req_ready, occupancy, err_count} !== '0) begin
         n_bad++;
         $display("FAIL reset_state: valid %b ready %b occ %0d err %0d, required all 0",
                  rsp_valid, req_ready, occupancy, err_count);
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      n_cmp++;
      if (req_ready !== 1'b1) begin n_bad++; $display("FAIL ready_after_reset: got %b, required 1", req_ready); end
      @(negedge clk);
   endtask

   task automatic test_add_overflow();
      bit acc;
      rsp_ready = 1'b0;
      send(4'd1, 2'd2, 32'hFFFF_FFFF, 32'd1);
      sb_cycle(acc);
      #1;
      n_cmp++;
      if ({rsp_valid, rsp_resp, rsp_flow, rsp_data, rsp_tag, err_count} !== {1'b1, 2'd2, 1'b1, 32'd0, 2'd2, 16'd1}) begin
         n_bad++;
         $display("FAIL add_ovf: valid %b resp %0d flow %b data %h tag %0d err %0d, required 1 2 1 0 2 1",
                  rsp_valid, rsp_resp, rsp_flow, rsp_data, rsp_tag, err_count);
      end
      @(negedge clk);
      drain(10);
   endtask

   task automatic test_sub_shift();
      rsp_ready = 1'b1;
      send(4'd2, 2'd0, 32'd5, 32'd7);
      send(4'd2, 2'd1, 32'd7, 32'd5);
      send(4'd7, 2'd2, 32'h8000_0000, 32'd4);
      send(4'd5, 2'd3, 32'd1, 32'd33);
      send(4'd6, 2'd0, 32'hF000_000F, 32'd8);
      send(4'd3, 2'd1, 32'hFF00_FF00, 32'h0FF0_0FF0);
      send(4'd4, 2'd2, 32'hFF00_0000, 32'h0000_00FF);
      send(4'd1, 2'd3, 32'd100, 32'd23);
      drain(10);
   endtask

   task automatic test_back_to_back();
      bit acc;
      int n_acc;
      rsp_ready = 1'b0;
      req_valid = 1'b1; req_cmd = 4'd4; req_tag = '0; d1 = 32'h10; d2 = 32'h1;
      n_acc = 0;
      for (int i = 0; i < 8; i++) begin
         sb_cycle(acc);
         if (acc) begin n_acc++; req_tag = req_tag + 1'b1; d2 = d2 << 1; end
      end
      req_valid = 1'b0;
      #1;
      n_cmp++;
      if (n_acc != FD || req_ready !== 1'b0 || occupancy !== ($clog2(FD)+1)'(FD)) begin
         n_bad++;
         $display("FAIL backpressure: accepted %0d ready %b occ %0d, required %0d 0 %0d",
                  n_acc, req_ready, occupancy, FD, FD);
      end
      @(negedge clk);
      drain(10);
   endtask

   task automatic test_stream();
      logic [3:0] cmds [20] = '{1, 2, 0, 3, 12, 4, 5, 6, 7, 1, 0, 2, 9, 3, 4, 15, 5, 6, 7, 1};
      int c0, p0, nz;
      rsp_ready = 1'b1;
      c0 = n_cyc; p0 = n_pop; nz = 0;
      for (int i = 0; i < 20; i++) begin
         if (cmds[i] != 4'd0) nz++;
         send(cmds[i], TW'(i), $urandom, (i % 3 == 0) ? 32'($urandom_range(0, 40)) : $urandom);
         req_valid = 1'b1;
      end
      req_valid = 1'b0;
      n_cmp++;
      if (n_cyc - c0 != 20) begin
         n_bad++; $display("FAIL stream_stall: cycles %0d, required 20", n_cyc - c0);
      end
      drain(3);
      n_cmp++;
      if (n_pop - p0 != nz) begin
         n_bad++; $display("FAIL stream_count: responses %0d, required %0d", n_pop - p0, nz);
      end
   endtask

   task automatic test_reset_flight();
      bit acc;
      rsp_ready = 1'b0;
      send(4'd12, 2'd1, 32'd1, 32'd2);
      send(4'd2, 2'd2, 32'd1, 32'd2);
      send(4'd3, 2'd3, 32'hF, 32'h3);
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({rsp_valid, req_ready, occupancy, err_count} !== '0) begin
         n_bad++;
         $display("FAIL reset_flight: valid %b ready %b occ %0d err %0d, required all 0",
                  rsp_valid, req_ready, occupancy, err_count);
      end
      sbq.delete();
      exp_err = 0;
      req_valid = 1'b1; req_cmd = 4'd1; d1 = 32'd3; d2 = 32'd4;
      @(negedge clk);
      sb_cycle(acc);
      req_valid = 1'b0;
      rst_n = 1'b1;
      rsp_ready = 1'b1;
      for (int i = 0; i < 6; i++) sb_cycle(acc);
      #1;
      n_cmp++;
      if (err_count !== 16'd0 || rsp_valid !== 1'b0) begin
         n_bad++; $display("FAIL stale_after_reset: err %0d valid %b, required 0 0", err_count, rsp_valid);
      end
      @(negedge clk);
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_add_overflow();
      test_sub_shift();
      test_back_to_back();
      test_stream();
      test_reset_flight();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: bench still running, required finish");
      $fatal(1);
   end
endmodule
